aca_vlsa: RTL and testbench

- Parametrised, variable-latency speculative adder. Successor to the fixed 32-bit, 4-bit-window carry-select approximate adder.
- Produces a block-speculative (ACA-CSU style) sum, detects whether the speculation was wrong, and optionally ripples an exact correction over extra cycles.
- Sits in the approximate-arithmetic datapath behind a valid/ready handshake. One operation in flight at a time.

---
 rtl/aca_pkg.sv | 18 +
 rtl/aca_blk_add.sv | 23 ++
 rtl/aca_vlsa.sv | 184 ++++++++++++++++++
 tb/tb_aca_vlsa.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aca_pkg.sv
// Shared types and helpers for the variable-latency speculative adder.
// Optional error statistics are enabled by defining ACA_ERR_STATS_EN.
package aca_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SPEC,
    CORR,
    DONE
  } state_t;

  localparam int ERR_CNT_W = 16;

  function automatic int nblk(input int width, input int win);
    return width / win;
  endfunction

endpackage

// File: rtl/aca_blk_add.sv
// One WIN-bit speculation block.
// Produces the sum with carry-in, plus block generate and propagate.
module aca_blk_add #(
  parameter int WIN = 4
) (
  input  logic [WIN-1:0] a,
  input  logic [WIN-1:0] b,
  input  logic           ci,
  output logic [WIN-1:0] s,
  output logic           g,
  output logic           p
);

  logic [WIN:0] w_sum;

  assign w_sum = {1'b0, a} + {1'b0, b} + {{WIN{1'b0}}, ci};
  assign s     = w_sum[WIN-1:0];
  assign p     = &(a ^ b);
  // A fully propagating block cannot generate, so the carry-in
  // contribution is removed to obtain the carry-out with ci=0.
  assign g     = w_sum[WIN] & ~(p & ci);

endmodule

// File: rtl/aca_vlsa.sv
// Variable-latency speculative adder with exact error detection.
// Define ACA_ERR_STATS_EN to add the err_count / stats_clr ports.
module aca_vlsa
  import aca_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int WIN   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             approx_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             err,
`ifdef ACA_ERR_STATS_EN
  input  logic             stats_clr,
  output logic [ERR_CNT_W-1:0] err_count,
`endif
  output logic             corrected
);

  localparam int NBLK = nblk(WIDTH, WIN);
  localparam int KW   = (NBLK > 1) ? $clog2(NBLK) : 1;

  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b, r_work, r_sum;
  logic             r_cin, r_am, r_tc;
  logic             r_cout, r_err, r_corr, r_out_valid;
  logic [KW-1:0]    r_k;

  logic [NBLK-1:0]  w_g, w_p, w_ci;
  logic [WIDTH-1:0] w_ssum;
  logic             w_scout;
  logic [WIDTH:0]   w_exact;
  logic             w_err;

  logic [WIN-1:0]   w_ca, w_cb, w_cs;
  logic             w_cg, w_cp, w_ctc, w_last;
  logic [WIDTH-1:0] w_work_nx;
  logic             w_unused;

  for (genvar j = 0; j < NBLK; j++) begin : g_blk
    if (j == 0) begin : g_first
      assign w_ci[j] = r_cin;
    end else begin : g_rest
      assign w_ci[j] = w_g[j-1];
    end
    aca_blk_add #(.WIN(WIN)) u_blk (
      .a  (r_a[j*WIN +: WIN]),
      .b  (r_b[j*WIN +: WIN]),
      .ci (w_ci[j]),
      .s  (w_ssum[j*WIN +: WIN]),
      .g  (w_g[j]),
      .p  (w_p[j])
    );
  end

  assign w_scout  = w_g[NBLK-1];
  assign w_exact  = {1'b0, r_a} + {1'b0, r_b}
                  + {{WIDTH{1'b0}}, r_cin};
  assign w_err    = ({w_scout, w_ssum} != w_exact);
  assign w_unused = ^w_p;

  assign w_ca = r_a[r_k*WIN +: WIN];
  assign w_cb = r_b[r_k*WIN +: WIN];

  aca_blk_add #(.WIN(WIN)) u_corr (
    .a  (w_ca),
    .b  (w_cb),
    .ci (r_tc),
    .s  (w_cs),
    .g  (w_cg),
    .p  (w_cp)
  );

  assign w_ctc  = w_cg | (w_cp & r_tc);
  assign w_last = (r_k == KW'(NBLK - 1));

  // Working sum with block k replaced by its corrected value.
  always_comb begin
    w_work_nx = r_work;
    w_work_nx[r_k*WIN +: WIN] = w_cs;
  end

  // Control FSM with registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_cin       <= 1'b0;
      r_am        <= 1'b0;
      r_tc        <= 1'b0;
      r_k         <= '0;
      r_work      <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_err       <= 1'b0;
      r_corr      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_cin   <= cin;
            r_am    <= approx_mode;
            r_state <= SPEC;
          end
        end
        SPEC: begin
          if (!w_err || r_am) begin
            r_sum       <= w_ssum;
            r_cout      <= w_scout;
            r_err       <= w_err;
            r_corr      <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_work  <= w_ssum;
            r_tc    <= w_g[0] | (w_p[0] & r_cin);
            r_k     <= KW'(1);
            r_state <= CORR;
          end
        end
        CORR: begin
          r_work <= w_work_nx;
          r_tc   <= w_ctc;
          if (w_last) begin
            r_sum       <= w_work_nx;
            r_cout      <= w_ctc;
            r_err       <= 1'b1;
            r_corr      <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign err       = r_err;
  assign corrected = r_corr;

`ifdef ACA_ERR_STATS_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;

  // Saturating count of retired results that carried err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (stats_clr) begin
      r_err_cnt <= '0;
    end else if (r_out_valid && out_ready && r_err
                 && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign err_count = r_err_cnt;
`endif

endmodule

// File: tb/tb_aca_vlsa.sv
// Scoreboard bench for aca_vlsa (WIDTH=32, WIN=4).
// Covers ACA_ERR_STATS_EN counting when that macro is defined.
module tb_aca_vlsa;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a, op_b;
  logic        op_cin, op_am;
  logic        out_valid, out_ready;
  logic [31:0] dut_sum;
  logic        dut_cout, dut_err, dut_corr;
`ifdef ACA_ERR_STATS_EN
  logic        stats_clr;
  logic [15:0] err_count;
`endif

  aca_vlsa #(.WIDTH(32), .WIN(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (op_a),
    .b           (op_b),
    .cin         (op_cin),
    .approx_mode (op_am),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sum         (dut_sum),
    .cout        (dut_cout),
    .err         (dut_err),
`ifdef ACA_ERR_STATS_EN
    .stats_clr   (stats_clr),
    .err_count   (err_count),
`endif
    .corrected   (dut_corr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        err;
    logic        corr;
    int          lat;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   acc_cyc = 0;
  int   first_cyc = 0;
  bit   seen    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops and compares on every retire handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !seen) begin
        seen = 1;
        first_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk({e.name, ".sum"}, 64'(dut_sum), 64'(e.sum));
          chk({e.name, ".cout"}, 64'(dut_cout), 64'(e.cout));
          chk({e.name, ".err"}, 64'(dut_err), 64'(e.err));
          chk({e.name, ".corr"}, 64'(dut_corr), 64'(e.corr));
          chk({e.name, ".lat"}, 64'(first_cyc - acc_cyc + 1),
              64'(e.lat));
        end
        seen = 0;
      end
    end else begin
      seen = 0;
    end
  end

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                       input logic ic, input logic iam,
                       input logic [31:0] es, input logic ec,
                       input logic ee, input logic er,
                       input int el, input string nm,
                       input bit push);
    int t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk({nm, ".accept_timeout"}, 64'd0, 64'd1);
    op_a = ia;
    op_b = ib;
    op_cin = ic;
    op_am = iam;
    in_valid = 1'b1;
    e.sum = es; e.cout = ec; e.err = ee; e.corr = er;
    e.lat = el; e.name = nm;
    if (push) q.push_back(e);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() > 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (q.size() > 0) begin
      chk("drain_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    rst = 1'b1;
    in_valid = 1'b0;
    op_a = '0; op_b = '0; op_cin = 1'b0; op_am = 1'b0;
    out_ready = 1'b1;
`ifdef ACA_ERR_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.sum", 64'(dut_sum), 64'd0);
    chk("rst.flags", 64'({dut_cout, dut_err, dut_corr}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(32'h0000000F, 32'h00000001, 0, 0,
          32'h00000010, 0, 0, 0, 2, "f_plus_1", 1);
    issue(32'h000000FF, 32'h00000001, 0, 1,
          32'h00000000, 0, 1, 0, 2, "ff_approx", 1);
    issue(32'h000000FF, 32'h00000001, 0, 0,
          32'h00000100, 0, 1, 1, 9, "ff_exact", 1);
    issue(32'hFFFFFFFF, 32'h00000001, 0, 1,
          32'hFFFFFF00, 0, 1, 0, 2, "all1_approx", 1);
    issue(32'hFFFFFFFF, 32'h00000001, 0, 0,
          32'h00000000, 1, 1, 1, 9, "all1_exact", 1);
    issue(32'h00000010, 32'h00000020, 1, 0,
          32'h00000031, 0, 0, 0, 2, "cin_clean", 1);
    issue(32'h000000F0, 32'h00000010, 0, 0,
          32'h00000100, 0, 0, 0, 2, "spec_hit", 1);
    issue(32'h80000000, 32'h80000000, 0, 0,
          32'h00000000, 1, 0, 0, 2, "top_cout", 1);
    drain();

    // Backpressure: result held while consumer stalls.
    out_ready = 1'b0;
    issue(32'h12345678, 32'h11111111, 0, 0,
          32'h23456789, 0, 0, 0, 2, "bp_a", 1);
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("bp.out_valid", 64'(out_valid), 64'd1);
    op_a = 32'hFFFF0000;
    op_b = 32'h0000FFFF;
    op_cin = 1'b1;
    op_am = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp.hold_sum", 64'(dut_sum), 64'h23456789);
      chk("bp.hold_flags", 64'({out_valid, dut_cout, dut_err}),
          64'b100);
      chk("bp.in_ready_low", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    begin
      exp_t e;
      e.sum = 32'h00000000; e.cout = 1; e.err = 1; e.corr = 1;
      e.lat = 9; e.name = "bp_b";
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp.after_hs_valid", 64'(out_valid), 64'd0);
    chk("bp.after_hs_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    chk("bp.accepted_next", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    drain();

    // Reset in the 4th correction cycle discards the operation.
    issue(32'hFFFFFFFF, 32'h00000001, 0, 0,
          32'h0, 0, 0, 0, 0, "discard", 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("corr.busy", 64'({out_valid, in_ready}), 64'b00);
    rst = 1'b1;
    #1;
    chk("mid_rst.out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst.in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    issue(32'h00000003, 32'h00000004, 0, 0,
          32'h00000007, 0, 0, 0, 2, "post_rst", 1);
    drain();

`ifdef ACA_ERR_STATS_EN
    @(negedge clk);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    chk("stats.cleared0", 64'(err_count), 64'd0);
    issue(32'h000000FF, 32'h00000001, 0, 1,
          32'h00000000, 0, 1, 0, 2, "st_e1", 1);
    issue(32'h000000FF, 32'h00000001, 0, 0,
          32'h00000100, 0, 1, 1, 9, "st_e2", 1);
    issue(32'h00000003, 32'h00000004, 0, 0,
          32'h00000007, 0, 0, 0, 2, "st_ok", 1);
    issue(32'hFFFFFFFF, 32'h00000001, 0, 1,
          32'hFFFFFF00, 0, 1, 0, 2, "st_e3", 1);
    drain();
    chk("stats.count3", 64'(err_count), 64'd3);
    @(negedge clk);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    chk("stats.cleared", 64'(err_count), 64'd0);
`endif

    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
